// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates I/D cache misses onto one L2 burst and steers the returning beats; define FILL_ARB_RR_EN for round-robin ties
module cache_fill_arbiter #(
   parameter int B      = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              ic_miss_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic              dc_miss_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   output logic              l2_req_o,
   output logic [ADDR_W-1:0] l2_addr_o,
   input  logic              l2_ack_i,
   input  logic              l2_rvalid_i,
   input  logic [63:0]       l2_rdata_i,
   output logic              ic_repl_grant_o,
   output logic              dc_repl_grant_o,
   output logic [63:0]       rep_word_o,
   output logic              fill_done_o,
   output logic              busy_o
);
   localparam int BEATS = B / 8;
   localparam int CW = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(B - 1);
   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
   state_t state, state_nxt;
   logic owner;
   logic [ADDR_W-1:0] addr_q;
   logic [CW-1:0] cnt;
   logic tie_dc, pick_dc, last_beat;
`ifdef FILL_ARB_RR_EN
   // last_ic=0 after reset means the data cache owned last, so IC wins the first tie
   logic last_ic;
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) last_ic <= 1'b0;
      else if (state == DONE) last_ic <= ~owner;
   assign tie_dc = last_ic;
`else
   assign tie_dc = 1'b0;
`endif
   assign pick_dc = dc_miss_i & (~ic_miss_i | tie_dc);
   assign last_beat = state == FILL && l2_rvalid_i && cnt == CW'(BEATS - 1);
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state  <= IDLE;
         owner  <= 1'b0;
         addr_q <= '0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (ic_miss_i || dc_miss_i)) begin
            owner  <= pick_dc;
            addr_q <= (pick_dc ? dc_addr_i : ic_addr_i) & MASK;
         end
         if (state == REQ) cnt <= '0;
         else if (state == FILL && l2_rvalid_i) cnt <= cnt + CW'(1);
      end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = (ic_miss_i || dc_miss_i) ? REQ : IDLE;
         REQ:  state_nxt = l2_ack_i ? FILL : REQ;
         FILL: state_nxt = last_beat ? DONE : FILL;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      l2_req_o        = state == REQ;
      l2_addr_o       = state == REQ ? addr_q : '0;
      ic_repl_grant_o = state == FILL && !owner && l2_rvalid_i;
      dc_repl_grant_o = state == FILL && owner && l2_rvalid_i;
      rep_word_o      = state == FILL ? l2_rdata_i : '0;
      fill_done_o     = last_beat;
      busy_o          = state != IDLE;
   end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: directed checks of arbitration, burst sequencing, stalls and reset
module tb_cache_fill_arbiter;
   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        ic_miss_i = 1'b0, dc_miss_i = 1'b0;
   logic [31:0] ic_addr_i = '0, dc_addr_i = '0;
   logic        l2_req_o, l2_ack_i = 1'b0, l2_rvalid_i = 1'b0;
   logic [31:0] l2_addr_o;
   logic [63:0] l2_rdata_i = '0, rep_word_o;
   logic        ic_repl_grant_o, dc_repl_grant_o, fill_done_o, busy_o;
   int          n_chk = 0, n_fail = 0;

   cache_fill_arbiter dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
      .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i),
      .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_ack_i(l2_ack_i),
      .l2_rvalid_i(l2_rvalid_i), .l2_rdata_i(l2_rdata_i),
      .ic_repl_grant_o(ic_repl_grant_o), .dc_repl_grant_o(dc_repl_grant_o),
      .rep_word_o(rep_word_o), .fill_done_o(fill_done_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, {59'd0, l2_req_o, ic_repl_grant_o, dc_repl_grant_o, fill_done_o, busy_o}, 64'd0);
      check({tag, "_addr"}, {32'd0, l2_addr_o}, 64'd0);
   endtask

   // Starts in IDLE with misses already driven; ends back in IDLE.
   task automatic fill(input string tag, input logic exp_dc, input logic [31:0] exp_addr,
                       input int ack_wait, input bit gap, input bit drop);
      step();
      check({tag, "_req"}, {63'd0, l2_req_o}, 64'd1);
      check({tag, "_addr"}, {32'd0, l2_addr_o}, {32'd0, exp_addr});
      check({tag, "_busy_req"}, {63'd0, busy_o}, 64'd1);
      if (drop) begin
         ic_miss_i = 1'b0;
         dc_miss_i = 1'b0;
      end
      repeat (ack_wait) begin
         step();
         check({tag, "_stall_req"}, {63'd0, l2_req_o}, 64'd1);
         check({tag, "_stall_addr"}, {32'd0, l2_addr_o}, {32'd0, exp_addr});
      end
      l2_ack_i = 1'b1;
      step();
      l2_ack_i = 1'b0;
      check({tag, "_fill_addr"}, {31'd0, l2_req_o, l2_addr_o}, 64'd0);
      for (int b = 0; b < 8; b++) begin
         if (gap && b == 4) begin
            l2_rvalid_i = 1'b0;
            repeat (3) begin
               #1;
               check({tag, "_gap"}, {62'd0, ic_repl_grant_o, dc_repl_grant_o}, 64'd0);
               step();
            end
         end
         l2_rvalid_i = 1'b1;
         l2_rdata_i = 64'hC0DE_0000_0000_0000 | 64'(b);
         #1;
         check({tag, "_grant"}, {62'd0, ic_repl_grant_o, dc_repl_grant_o}, {62'd0, ~exp_dc, exp_dc});
         check({tag, "_word"}, rep_word_o, 64'hC0DE_0000_0000_0000 | 64'(b));
         check({tag, "_done"}, {63'd0, fill_done_o}, {63'd0, b == 7});
         step();
      end
      l2_rvalid_i = 1'b1;
      #1;
      check({tag, "_done_st"}, {60'd0, ic_repl_grant_o, dc_repl_grant_o, fill_done_o, busy_o}, 64'd1);
      l2_rvalid_i = 1'b0;
      step();
      check({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
   endtask

   initial begin
      #1;
      check_quiet("reset");
      step();
      step();
      reset_n_i = 1'b1;
      check_quiet("post_reset");

      ic_miss_i = 1'b1;
      ic_addr_i = 32'h0000_1234;
      fill("ic_fill", 1'b0, 32'h0000_1200, 1, 1'b0, 1'b1);

      dc_miss_i = 1'b1;
      dc_addr_i = 32'hABCD_EF7F;
      fill("stall", 1'b1, 32'hABCD_EF40, 10, 1'b1, 1'b1);

      ic_addr_i = 32'h0000_2008;
      dc_addr_i = 32'h0000_3010;
      ic_miss_i = 1'b1;
      dc_miss_i = 1'b1;
`ifdef FILL_ARB_RR_EN
      fill("rr1", 1'b0, 32'h0000_2000, 0, 1'b0, 1'b0);
      fill("rr2", 1'b1, 32'h0000_3000, 0, 1'b0, 1'b0);
      fill("rr3", 1'b0, 32'h0000_2000, 0, 1'b0, 1'b0);
      fill("rr4", 1'b1, 32'h0000_3000, 1, 1'b0, 1'b0);
`else
      fill("fp1", 1'b0, 32'h0000_2000, 0, 1'b0, 1'b0);
      fill("fp2", 1'b0, 32'h0000_2000, 0, 1'b0, 1'b0);
      fill("fp3", 1'b0, 32'h0000_2000, 1, 1'b0, 1'b0);
`endif
      ic_miss_i = 1'b0;
      dc_miss_i = 1'b0;
      step();
      check("idle_no_miss", {63'd0, busy_o}, 64'd0);

      dc_miss_i = 1'b1;
      dc_addr_i = 32'h0000_0FC0;
      fill("withdrawn", 1'b1, 32'h0000_0FC0, 0, 1'b0, 1'b1);

      ic_miss_i = 1'b1;
      ic_addr_i = 32'h0000_5555;
      step();
      ic_miss_i = 1'b0;
      l2_ack_i = 1'b1;
      step();
      l2_ack_i = 1'b0;
      l2_rvalid_i = 1'b1;
      repeat (3) step();
      #1;
      check("pre_rst_grant", {63'd0, ic_repl_grant_o}, 64'd1);
      reset_n_i = 1'b0;
      #1;
      check_quiet("rst_fill");
      check("rst_word", rep_word_o, 64'd0);
      step();
      reset_n_i = 1'b1;
      repeat (4) begin
         #1;
         check_quiet("after_rst");
         step();
      end
      l2_rvalid_i = 1'b0;

      reset_n_i = 1'b0;
      ic_miss_i = 1'b1;
      ic_addr_i = 32'h0000_7780;
      step();
      check("held_rst_busy", {63'd0, busy_o}, 64'd0);
      reset_n_i = 1'b1;
      fill("held_miss", 1'b0, 32'h0000_7780, 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
